// File: rtl/seg_serial_ctrl.sv
// Serial transfer sequencer for the 8-digit seven-segment shift-register chain.
// Shifts a captured 64-bit image MSB first, strobes the latch, and generates the blink wave.
module seg_serial_ctrl #(
   parameter int CLK_DIV    = 2,
   parameter int FLASH_BITS = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] seg_txt,
   output logic        busy,
   output logic        done,
   output logic        flash,
   output logic        seg_clk,
   output logic        seg_dout,
   output logic        seg_load,
   output logic        seg_clrn
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

   state_t          state, state_next;
   logic [63:0]     sreg, sreg_next;
   logic [5:0]      bit_cnt, bit_cnt_next;
   logic [DW-1:0]   div_cnt, div_cnt_next;
   logic            half, half_next;
   logic            pending, pending_next;
   logic [FLASH_BITS-1:0] flash_cnt;

   always_comb begin
      state_next   = state;
      sreg_next    = sreg;
      bit_cnt_next = bit_cnt;
      div_cnt_next = div_cnt;
      half_next    = half;
      pending_next = pending;
      case (state)
         IDLE: begin
            if (start) begin
               state_next   = SHIFT;
               sreg_next    = seg_txt;
               bit_cnt_next = 6'd63;
               div_cnt_next = '0;
               half_next    = 1'b0;
            end
         end
         SHIFT: begin
            pending_next = pending | start;
            if (div_cnt == DIV_LAST) begin
               div_cnt_next = '0;
               if (half) begin
                  // end of the high phase: advance to the next bit
                  half_next    = 1'b0;
                  sreg_next    = {sreg[62:0], 1'b0};
                  bit_cnt_next = bit_cnt - 6'd1;
                  if (bit_cnt == 6'd0)
                     state_next = LATCH;
               end else begin
                  half_next = 1'b1;
               end
            end else begin
               div_cnt_next = div_cnt + 1'b1;
            end
         end
         LATCH: begin
            pending_next = pending | start;
            if (div_cnt == DIV_LAST) begin
               div_cnt_next = '0;
               state_next   = DONE;
            end else begin
               div_cnt_next = div_cnt + 1'b1;
            end
         end
         DONE: begin
            // a request arriving in this very cycle relaunches just like a queued one
            if (pending || start) begin
               pending_next = 1'b0;
               state_next   = SHIFT;
               sreg_next    = seg_txt;
               bit_cnt_next = 6'd63;
               div_cnt_next = '0;
               half_next    = 1'b0;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // outputs are registered from the next-state values so they line up with the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sreg      <= '0;
         bit_cnt   <= '0;
         div_cnt   <= '0;
         half      <= 1'b0;
         pending   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         seg_clk   <= 1'b0;
         seg_dout  <= 1'b0;
         seg_load  <= 1'b0;
         seg_clrn  <= 1'b0;
         flash_cnt <= '0;
      end else begin
         state     <= state_next;
         sreg      <= sreg_next;
         bit_cnt   <= bit_cnt_next;
         div_cnt   <= div_cnt_next;
         half      <= half_next;
         pending   <= pending_next;
         busy      <= (state_next != IDLE);
         done      <= (state_next == DONE);
         seg_clk   <= (state_next == SHIFT) && half_next;
         seg_dout  <= sreg_next[63];
         seg_load  <= (state_next == LATCH);
         seg_clrn  <= 1'b1;
         flash_cnt <= flash_cnt + 1'b1;
      end
   end

   assign flash = flash_cnt[FLASH_BITS-1];

endmodule

// File: tb/tb_seg_serial_ctrl.sv
// Self-checking bench for seg_serial_ctrl: scoreboard of serial bits plus per-scenario timing checks.
module tb_seg_serial_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [63:0] seg_txt;
   logic        busy, done, flash, seg_clk, seg_dout, seg_load, seg_clrn;

   int errors = 0;
   int checks = 0;

   bit sb[$];
   int rise_cnt = 0;
   bit prev_clk = 1'b0;
   bit prev_load = 1'b0;

   seg_serial_ctrl #(.CLK_DIV(2), .FLASH_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .seg_txt(seg_txt),
      .busy(busy), .done(done), .flash(flash), .seg_clk(seg_clk),
      .seg_dout(seg_dout), .seg_load(seg_load), .seg_clrn(seg_clrn)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_image(input logic [63:0] img);
      for (int b = 63; b >= 0; b--) sb.push_back(img[b]);
   endtask

   // Scoreboard monitor: each seg_clk rise pops one expected bit; latch only after 64 bits.
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         sb.delete();
         rise_cnt  = 0;
         prev_clk  = 1'b0;
         prev_load = 1'b0;
      end else begin
         if (seg_clk && !prev_clk) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow: seg_clk rise with no expected bit, dout=%0b", seg_dout);
            end else begin
               bit exp_bit;
               exp_bit = sb.pop_front();
               if (seg_dout !== exp_bit) begin
                  errors++;
                  $display("FAIL sb_bit: rise %0d got %0b expected %0b", rise_cnt, seg_dout, exp_bit);
               end
            end
            rise_cnt++;
         end
         if (seg_load && !prev_load) begin
            checks++;
            if (rise_cnt !== 64) begin
               errors++;
               $display("FAIL load_full: rises before load got %0d expected 64", rise_cnt);
            end
            $display("transfer latched after %0d bits at %0t", rise_cnt, $time);
            rise_cnt = 0;
         end
         prev_clk  = seg_clk;
         prev_load = seg_load;
      end
   end

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b1; seg_txt = 64'hDEAD_BEEF_0123_4567;
      repeat (3) tick();
      checks++;
      if ({busy, done, flash, seg_clk, seg_dout, seg_load, seg_clrn} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 0000000",
                  {busy, done, flash, seg_clk, seg_dout, seg_load, seg_clrn});
      end
      rst_n = 1'b1; start = 1'b0;
      tick();
      checks++;
      if (seg_clrn !== 1'b1) begin
         errors++;
         $display("FAIL clrn_release: got %0b expected 1", seg_clrn);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || seg_clk !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b seg_clk=%0b expected 0 0", busy, seg_clk);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_single;
      logic exp_clk;
      seg_txt = 64'hA5C3_0FF0_1234_8001;
      push_image(seg_txt);
      start = 1'b1;
      for (int c = 1; c <= 262; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         exp_clk = (c <= 256) && (((c - 1) % 4) >= 2);
         checks++;
         if (seg_clk !== exp_clk || seg_load !== (c == 257 || c == 258) ||
             done !== (c == 259) || busy !== (c <= 259)) begin
            errors++;
            $display("FAIL single_timing c=%0d: clk/load/done/busy got %0b%0b%0b%0b expected %0b%0b%0b%0b",
                     c, seg_clk, seg_load, done, busy, exp_clk, (c == 257 || c == 258), (c == 259), (c <= 259));
         end
      end
      $display("test_single done");
   endtask

   task automatic test_queued;
      seg_txt = 64'hA5C3_0FF0_1234_8001;
      push_image(seg_txt);
      start = 1'b1;
      for (int c = 1; c <= 521; c++) begin
         tick();
         if (c == 1 || c == 101) start = 1'b0;
         if (c == 100) start = 1'b1;
         if (c == 200) seg_txt = 64'hFFFF_0000_FFFF_0000;
         if (c == 259) push_image(64'hFFFF_0000_FFFF_0000);
         checks++;
         if (done !== (c == 259 || c == 518) || busy !== (c <= 518)) begin
            errors++;
            $display("FAIL queued c=%0d: done/busy got %0b%0b expected %0b%0b",
                     c, done, busy, (c == 259 || c == 518), (c <= 518));
         end
      end
      $display("test_queued done");
   endtask

   task automatic test_collapse;
      int n_done = 0;
      seg_txt = 64'h0123_4567_89AB_CDEF;
      push_image(seg_txt);
      start = 1'b1;
      for (int c = 1; c <= 560; c++) begin
         tick();
         start = (c == 10 || c == 50 || c == 90);
         if (c == 259) push_image(seg_txt);
         if (done) n_done++;
         if (c == 519) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL collapse_idle: busy got %0b expected 0", busy);
            end
         end
      end
      checks++;
      if (n_done !== 2) begin
         errors++;
         $display("FAIL collapse_done_count: got %0d expected 2", n_done);
      end
      $display("test_collapse done pulses=%0d", n_done);
   endtask

   task automatic test_reset_mid;
      seg_txt = 64'hF0F0_1111_2222_3333;
      push_image(seg_txt);
      start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (c == 1) start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, flash, seg_clk, seg_dout, seg_load, seg_clrn} !== 7'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got %b expected 0000000",
                  {busy, done, flash, seg_clk, seg_dout, seg_load, seg_clrn});
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (seg_load !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: load=%0b done=%0b expected 0 0", seg_load, done);
         end
      end
      rst_n = 1'b1;
      tick();
      seg_txt = 64'h8000_0000_0000_0001;
      push_image(seg_txt);
      start = 1'b1;
      for (int c = 1; c <= 261; c++) begin
         tick();
         if (c == 1) start = 1'b0;
         checks++;
         if (done !== (c == 259) || busy !== (c <= 259)) begin
            errors++;
            $display("FAIL reset_mid_relaunch c=%0d: done/busy got %0b%0b expected %0b%0b",
                     c, done, busy, (c == 259), (c <= 259));
         end
      end
      $display("test_reset_mid done");
   endtask

   task automatic test_flash;
      bit exp_flash;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (flash !== 1'b0) begin
         errors++;
         $display("FAIL flash_start: got %0b expected 0", flash);
      end
      seg_txt = 64'h5555_AAAA_5555_AAAA;
      push_image(seg_txt);
      start = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (i == 1) start = 1'b0;
         exp_flash = ((i % 16) >= 8);
         checks++;
         if (flash !== exp_flash) begin
            errors++;
            $display("FAIL flash_wave i=%0d: got %0b expected %0b", i, flash, exp_flash);
         end
      end
      $display("test_flash done");
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; seg_txt = '0;
      test_reset();
      test_single();
      test_queued();
      test_collapse();
      test_reset_mid();
      test_flash();
      repeat (2) tick();
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d bits expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #30_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
